// File: rtl/link_seq_ctrl.sv
// Frame sequencer: table init, settle, preamble/payload frames with gaps.
// Optional BER counter on payload symbols when LINK_BER_EN is defined.
module link_seq_ctrl #(
    parameter int INIT_CYCLES   = 16,
    parameter int SETTLE_SYMS   = 8,
    parameter int PREAMBLE_SYMS = 16,
    parameter int PAYLOAD_SYMS  = 128,
    parameter int GAP_SYMS      = 4,
    parameter int CNT_W         = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_frames,
    input  logic             sym_tick,
`ifdef LINK_BER_EN
    input  logic [1:0]       demod_in,
    input  logic [1:0]       ref_in,
    output logic [15:0]      err_cnt,
`endif
    output logic             init_tab,
    output logic             src_en,
    output logic             tx_en,
    output logic             sel_preamble,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETL_LAST = CNT_W'(SETTLE_SYMS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_SYMS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_SYMS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SYMS - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] nframes_q;
    logic             abort_q;
    logic             accept;
    logic             frame_inc;
    logic             stop;
    logic             run_end;

    // abort_q remembers an abort seen between symbol boundaries
    assign stop    = abort | abort_q;
    assign run_end = (nframes_q != '0) && (frame_cnt == nframes_q);

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        frame_inc = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_INIT;
                    accept  = 1'b1;
                end
            end
            S_INIT: begin
                if (abort)
                    state_n = S_IDLE;
                else if (sym_cnt == INIT_LAST)
                    state_n = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)
                    state_n = S_IDLE;
                else if (sym_tick && sym_cnt == SETL_LAST)
                    state_n = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (sym_tick) begin
                    if (stop)
                        state_n = S_GAP;
                    else if (sym_cnt == PRE_LAST)
                        state_n = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (sym_tick) begin
                    if (stop) begin
                        state_n = S_GAP;
                    end else if (sym_cnt == PAY_LAST) begin
                        state_n   = S_GAP;
                        frame_inc = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (sym_tick && sym_cnt == GAP_LAST) begin
                    if (stop || run_end)
                        state_n = S_IDLE;
                    else
                        state_n = S_PREAMBLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            sym_cnt      <= '0;
            nframes_q    <= '0;
            frame_cnt    <= '0;
            abort_q      <= 1'b0;
            init_tab     <= 1'b0;
            src_en       <= 1'b0;
            tx_en        <= 1'b0;
            sel_preamble <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                sym_cnt <= '0;
            else if (state == S_INIT || (sym_tick && state != S_IDLE))
                sym_cnt <= sym_cnt + 1'b1;

            if (accept) begin
                nframes_q <= num_frames;
                frame_cnt <= '0;
            end else if (frame_inc) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            if (state_n == S_IDLE)
                abort_q <= 1'b0;
            else if (abort && state != S_IDLE)
                abort_q <= 1'b1;

            // outputs decoded from the next state so they track it exactly
            init_tab     <= (state_n == S_INIT);
            src_en       <= (state_n == S_PAYLOAD);
            tx_en        <= (state_n == S_PREAMBLE) || (state_n == S_PAYLOAD);
            sel_preamble <= (state_n == S_PREAMBLE);
            busy         <= (state_n != S_IDLE);
            done         <= (state != S_IDLE) && (state_n == S_IDLE);
        end
    end

`ifdef LINK_BER_EN
    logic [1:0]  diff;
    logic [16:0] err_sum;

    assign diff    = demod_in ^ ref_in;
    assign err_sum = {1'b0, err_cnt} + 17'(diff[0]) + 17'(diff[1]);

    always_ff @(posedge sys_clk) begin
        if (!reset)
            err_cnt <= '0;
        else if (accept)
            err_cnt <= '0;
        else if (state == S_PAYLOAD && sym_tick)
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_link_seq_ctrl.sv
// Scoreboard bench for link_seq_ctrl: per-run phase counts vs a run model.
// Randomised symbol spacing, aborts, restarts and mid-run reset.
module tb_link_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sym_tick = 1'b0;
    logic [7:0] num_frames = '0;
    logic       init_tab;
    logic       src_en;
    logic       tx_en;
    logic       sel_preamble;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;
`ifdef LINK_BER_EN
    logic [1:0]  demod_in = '0;
    logic [1:0]  ref_in = '0;
    logic [15:0] err_cnt;
    int          pay_i = 0;
`endif

    always #5 sys_clk = ~sys_clk;

    link_seq_ctrl dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_frames   (num_frames),
        .sym_tick     (sym_tick),
`ifdef LINK_BER_EN
        .demod_in     (demod_in),
        .ref_in       (ref_in),
        .err_cnt      (err_cnt),
`endif
        .init_tab     (init_tab),
        .src_en       (src_en),
        .tx_en        (tx_en),
        .sel_preamble (sel_preamble),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .done         (done)
    );

    typedef struct {
        int init;
        int pre;
        int pay;
        int sil;
        int frames;
        bit tx;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   tick_en = 1'b1;
    bit   tick_fixed = 1'b1;
    bit   inj_en = 1'b0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic exp_t mk(int i, int p, int y, int s, int f, bit t, int e);
        exp_t r;
        r.init = i; r.pre = p; r.pay = y; r.sil = s;
        r.frames = f; r.tx = t; r.err = e;
        return r;
    endfunction

    // Whole-run model: `full` completed frames, optionally a frame aborted
    // in payload after j clean payload ticks (abort tick itself is payload).
    function automatic exp_t model(int full, bit ab, int j, int e);
        if (ab)
            return mk(16, 16 * (full + 1), 128 * full + j + 1,
                      8 + 4 * (full + 1), full, 1'b1, e);
        return mk(16, 16 * full, 128 * full, 8 + 4 * full, full, full > 0, e);
    endfunction

    // symbol strobe and BER stimulus, changed just after the clock edge
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (tick_en && gap == 0) begin
                sym_tick = 1'b1;
                gap = tick_fixed ? 3 : int'($urandom_range(1, 4));
`ifdef LINK_BER_EN
                ref_in = 2'($urandom);
                demod_in = ref_in;
                if (inj_en && src_en) begin
                    if (pay_i < 10)
                        demod_in = ref_in ^ 2'b01;
                    else if (pay_i < 15)
                        demod_in = ref_in ^ 2'b11;
                    pay_i++;
                end else if (inj_en && sel_preamble) begin
                    demod_in = ref_in ^ 2'b11;
                end
`endif
            end else begin
                sym_tick = 1'b0;
                if (gap > 0)
                    gap--;
`ifdef LINK_BER_EN
                demod_in = 2'($urandom);
                ref_in = 2'($urandom);
`endif
            end
        end
    end

    // monitor: accumulates observed phase lengths, scores them on done
    int m_init = 0, m_pre = 0, m_pay = 0, m_sil = 0;
    bit m_tx = 1'b0, post = 1'b0;

    always @(negedge sys_clk) begin
        exp_t e;
        if (!reset) begin
            m_init = 0; m_pre = 0; m_pay = 0; m_sil = 0;
            m_tx = 1'b0; post = 1'b0;
        end else begin
            if (post) begin
                chk("busy_after_done", int'(busy), 0);
                chk("done_width", int'(done), 0);
                post = 1'b0;
            end
            if (init_tab) m_init++;
            if (tx_en) m_tx = 1'b1;
            if (sym_tick) begin
                if (tx_en && sel_preamble) m_pre++;
                if (src_en) m_pay++;
                if (busy && !init_tab && !tx_en) m_sil++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("init_cycles", m_init, e.init);
                    chk("preamble_ticks", m_pre, e.pre);
                    chk("payload_ticks", m_pay, e.pay);
                    chk("silent_ticks", m_sil, e.sil);
                    chk("frame_cnt", int'(frame_cnt), e.frames);
                    chk("tx_seen", int'(m_tx), int'(e.tx));
`ifdef LINK_BER_EN
                    chk("err_cnt", int'(err_cnt), e.err);
`endif
                end
                m_init = 0; m_pre = 0; m_pay = 0; m_sil = 0;
                m_tx = 1'b0; post = 1'b1;
            end
        end
    end

    task automatic wait_ev(input int kind, input int arg, input int budget,
                           input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge sys_clk);
            n++;
            if (kind == 0)
                hit = !busy && exp_q.size() == 0;
            else if (kind == 1)
                hit = src_en && frame_cnt == arg[7:0];
            else if (kind == 2)
                hit = sel_preamble;
            else
                hit = busy && !init_tab;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: got timeout after %0d cycles expected event", name, budget);
        end
    endtask

    task automatic do_start(input int n, input bit expect_init);
        @(negedge sys_clk);
        start = 1'b1;
        num_frames = 8'(n);
`ifdef LINK_BER_EN
        if (expect_init) pay_i = 0;
`endif
        @(posedge sys_clk);
        #1;
        if (expect_init) chk("start_to_init_tab", int'(init_tab), 1);
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_init_tab"}, int'(init_tab), 0);
        chk({tag, "_src_en"}, int'(src_en), 0);
        chk({tag, "_tx_en"}, int'(tx_en), 0);
        chk({tag, "_sel_pre"}, int'(sel_preamble), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int n, j, cnt, k, e;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero("reset");
        @(negedge sys_clk);
        reset = 1'b1;

        // two frames, symbol every 4 cycles
        tick_fixed = 1'b1;
        exp_q.push_back(model(2, 1'b0, 0, 0));
        do_start(2, 1'b1);
        wait_ev(0, 0, 5000, "run_a_end");
        repeat (5) @(negedge sys_clk);
        chk("frame_cnt_hold_idle", int'(frame_cnt), 2);

        // random frame count, random spacing, start re-pulsed mid-payload
        tick_fixed = 1'b0;
        n = int'($urandom_range(1, 3));
        exp_q.push_back(model(n, 1'b0, 0, 0));
        do_start(n, 1'b1);
        wait_ev(1, 0, 3000, "run_b_payload");
        repeat (int'($urandom_range(1, 50))) @(negedge sys_clk);
        do_start(n + 3, 1'b0);
        chk("restart_ignored_busy", int'(busy), 1);
        wait_ev(0, 0, 10000, "run_b_end");

        // continuous mode, abort inside the sixth payload
        do_start(0, 1'b1);
        wait_ev(1, 5, 30000, "run_c_frame6");
        j = int'($urandom_range(0, 20));
        exp_q.push_back(model(5, 1'b1, j, 0));
        cnt = 0;
        while (cnt != j) begin
            if (sym_tick) cnt++;
            @(negedge sys_clk);
        end
        abort = 1'b1;
        k = 0;
        while (!sym_tick && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        @(posedge sys_clk);
        #1;
        chk("abort_tx_drop", int'(tx_en), 0);
        chk("abort_no_inc", int'(frame_cnt), 5);
        @(negedge sys_clk);
        abort = 1'b0;
        wait_ev(0, 0, 200, "run_c_end");

        // abort during settle with no symbols
        tick_en = 1'b0;
        exp_q.push_back(mk(16, 0, 0, 0, 0, 1'b0, 0));
        do_start(1, 1'b1);
        wait_ev(3, 0, 100, "run_d_settle");
        repeat (3) @(negedge sys_clk);
        abort = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("settle_abort_busy", int'(busy), 0);
        chk("settle_abort_done", int'(done), 1);
        chk("settle_abort_tx", int'(tx_en), 0);
        @(negedge sys_clk);
        abort = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("settle_abort_done_fall", int'(done), 0);
        tick_en = 1'b1;

        // start and abort together: start wins, abort next cycle
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        num_frames = 8'd1;
        @(negedge sys_clk);
        start = 1'b0;
        @(negedge sys_clk);
        abort = 1'b0;
        wait_ev(0, 0, 20, "run_e_end");

        // reset in preamble: silent clear, then a full replay
        do_start(1, 1'b1);
        wait_ev(2, 0, 600, "run_f_preamble");
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        chk_zero("midreset");
        reset = 1'b1;
        e = 10 * $countones(2'b01) + 5 * $countones(2'b11);
        inj_en = 1'b1;
        exp_q.push_back(model(1, 1'b0, 0, e));
        do_start(1, 1'b1);
        wait_ev(0, 0, 3000, "run_g_end");
        inj_en = 1'b0;

        repeat (3) @(negedge sys_clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
